// File: rtl/cpu_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// transaction owner codes and internal counter widths.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_CPU  = 2'b01;
    localparam logic [1:0] OWNER_DBG  = 2'b10;

    // Latency counter covers MEM_LAT up to 7, streak counter up to 15.
    localparam int LAT_CNT_W = 3;
    localparam int STREAK_W  = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the CPU and debug requesters. Debug wins by
// default; the CPU wins when it is alone or when debug has been granted
// MAX_DBG_STREAK times in a row while the CPU waited. halt blocks the CPU.
module mem_arb_pick
    import cpu_pkg::*;
#(
    parameter int MAX_DBG_STREAK = 4
) (
    input  logic                cpu_req,
    input  logic                dbg_req,
    input  logic                halt,
    input  logic [STREAK_W-1:0] streak,
    output logic                grant_cpu,
    output logic                grant_dbg
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DBG_STREAK);

    logic cpu_ok;

    // Pick at most one winner; the two grants are mutually exclusive.
    always_comb begin
        cpu_ok    = cpu_req & ~halt;
        grant_cpu = cpu_ok & (~dbg_req | (streak >= STREAK_MAX));
        grant_dbg = dbg_req & ~grant_cpu;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the multicycle CPU port and a debug/loader
// port. One transaction is in flight at a time: IDLE grants, BUSY waits
// MEM_LAT clocks for read data, DONE presents a one-cycle done pulse.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_LAT        = 1,
    parameter int MAX_DBG_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        owner
);

    localparam logic [LAT_CNT_W-1:0] LAT_LAST   = LAT_CNT_W'(MEM_LAT);
    localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_DBG_STREAK);

    arb_state_t           state_q, state_d;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic [STREAK_W-1:0]  streak;
    logic                 txn_we;
    logic                 grant_cpu, grant_dbg;
    logic                 lat_hit;

    mem_arb_pick #(
        .MAX_DBG_STREAK(MAX_DBG_STREAK)
    ) u_pick (
        .cpu_req  (cpu_req),
        .dbg_req  (dbg_req),
        .halt     (halt),
        .streak   (streak),
        .grant_cpu(grant_cpu),
        .grant_dbg(grant_dbg)
    );

    assign lat_hit   = (lat_cnt == LAT_LAST);
    assign cpu_stall = cpu_req & ~cpu_done;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_cpu || grant_dbg) state_d = ST_BUSY;
            ST_BUSY: if (lat_hit)                state_d = ST_DONE;
            ST_DONE:                             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // Transaction datapath: latch the winner at grant, count latency,
    // capture read data and pulse the owner's done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            txn_we    <= 1'b0;
            owner     <= OWNER_NONE;
            lat_cnt   <= '0;
            cpu_done  <= 1'b0;
            dbg_done  <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_cpu) begin
                        mem_addr <= cpu_addr;
                        mem_din  <= cpu_wdata;
                        mem_we   <= cpu_we;
                        txn_we   <= cpu_we;
                        owner    <= OWNER_CPU;
                        lat_cnt  <= '0;
                    end else if (grant_dbg) begin
                        mem_addr <= dbg_addr;
                        mem_din  <= dbg_wdata;
                        mem_we   <= dbg_we;
                        txn_we   <= dbg_we;
                        owner    <= OWNER_DBG;
                        lat_cnt  <= '0;
                    end
                end
                ST_BUSY: begin
                    mem_we <= 1'b0;
                    if (lat_hit) begin
                        if (!txn_we && owner == OWNER_CPU) cpu_rdata <= mem_dout;
                        if (!txn_we && owner == OWNER_DBG) dbg_rdata <= mem_dout;
                        cpu_done <= (owner == OWNER_CPU);
                        dbg_done <= (owner == OWNER_DBG);
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    cpu_done <= 1'b0;
                    dbg_done <= 1'b0;
                    owner    <= OWNER_NONE;
                end
                default: ;
            endcase
        end
    end

    // Consecutive debug grants taken while the CPU was waiting, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (state_q == ST_IDLE) begin
            if (grant_cpu || !cpu_req)
                streak <= '0;
            else if (grant_dbg && !halt && streak != STREAK_MAX)
                streak <= streak + 1'b1;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between two requesters: the multicycle CPU's memory port (the IorD-muxed address, B-register write data, instruction/MDR read data) and a debug/loader port used for program load and memory inspection.
- Sits between the CPU datapath and the Memory instance; the CPU control FSM holds its current state while cpu_stall is high.
- Serialises accesses through a single outstanding transaction.
- Debug has priority, with a starvation guard for the CPU and a halt input that freezes CPU access.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- MEM_LAT, 1, memory read latency in clocks from address sampled to dout valid; legal range 1..7.
- MAX_DBG_STREAK, 4, maximum consecutive debug grants while cpu_req is pending before the CPU is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- halt  in  1  when high, no new CPU grants are issued
- cpu_req  in  1  CPU access request, level, held until cpu_done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_done is high, held afterwards
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational)
- dbg_req  in  1  debug access request, level
- dbg_we  in  1  debug write enable
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_done  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  read data, held afterwards
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data
- owner  out  2  00 none, 01 cpu, 10 dbg; current transaction owner

Behaviour:
- Reset (rst low, async):
  - state IDLE; mem_we, cpu_done, dbg_done = 0.
  - mem_addr, mem_din, cpu_rdata, dbg_rdata = 0; owner = 00.
  - Streak counter = 0.
  - An in-flight transaction is abandoned: no done pulse, and a write is not retried.
- FSM states: IDLE -> BUSY -> DONE -> IDLE.
- IDLE: requests are sampled at each rising edge and arbitrated as follows.
  - Only dbg_req: grant dbg.
  - Only cpu_req and halt=0: grant cpu.
  - Both requests, halt=0: grant cpu if streak >= MAX_DBG_STREAK, else grant dbg.
  - cpu_req with halt=1: not granted; cpu_stall stays high.
- Grant edge:
  - Register the winner's addr, wdata and we into mem_addr, mem_din and mem_we.
  - Set owner; load the latency counter with 0; go to BUSY.
- BUSY:
  - mem_we is high only in the first BUSY cycle, then cleared.
  - The counter increments each cycle.
  - On the edge where counter == MEM_LAT: capture mem_dout into the owner's rdata (reads only; rdata is unchanged on writes), raise the owner's done, go to DONE.
- DONE:
  - done is high for exactly this cycle.
  - Requests are ignored; next edge -> IDLE, done = 0, owner = 00.
- Timing:
  - Request high before edge E0.
  - Done is high in the cycle after edge E0+MEM_LAT+1, i.e. 3 cycles after E0 at MEM_LAT=1.
  - Minimum spacing between back-to-back grants is MEM_LAT+3 cycles.
- Streak counter, saturating at MAX_DBG_STREAK:
  - +1 on a dbg grant while cpu_req=1 and halt=0.
  - Cleared on a cpu grant.
  - Cleared in any IDLE cycle with cpu_req=0.
- Request fields are latched at grant; later changes do not affect the transaction. Dropping req mid-transaction still completes it with a done pulse.
- halt rising mid CPU transaction: the transaction completes normally.
- cpu_done and dbg_done are never high simultaneously.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10).
  - Owner encoding constants.
- One natural sub-module, mem_arb_pick: combinational winner selection from cpu_req, dbg_req, halt and streak, producing grant_cpu and grant_dbg.

Test Plan:
- Single CPU read: preload addr 0x10 = 0xDEADBEEF, MEM_LAT=1; cpu_req with addr 0x10 at E0 -> cpu_done high in cycle after E0+2, cpu_rdata = 0xDEADBEEF, owner 01 during BUSY, cpu_stall high until done.
- Debug write then CPU read: dbg write 0x20 <- 0x12345678; mem_we high exactly one cycle; CPU reads 0x20 afterwards -> 0x12345678.
- Simultaneous requests: cpu_req and dbg_req held continuously (halt=0, MAX_DBG_STREAK=4) -> grant order dbg, dbg, dbg, dbg, cpu, repeating.
- halt=1 with cpu_req and dbg_req both held -> only dbg_done pulses and cpu_stall stays 1; drop halt -> next grant is cpu if streak saturated.
- Reset mid-BUSY: assert rst low during a CPU read -> all outputs 0 immediately, no cpu_done; after release, a new cpu_req completes normally.
- MEM_LAT=3 build: CPU read -> done in cycle after E0+4; rdata matches preloaded value.
